// File: rtl/rr_mem_sched.sv
// rtl/rr_mem_sched.sv - four-master round-robin scheduler for the shared memory port
// Grants one master per transaction, forwards its request, and returns the ack or a watchdog abort.
module rr_mem_sched #(
    parameter int NM      = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NM-1:0]     REQ,
    input  logic [NM*AW-1:0]  m_addr,
    input  logic [NM*DW-1:0]  m_wdata,
    input  logic [NM-1:0]     m_wr,
    output logic [NM-1:0]     GNT,
    output logic              mem_valid,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_wr,
    output logic [1:0]        mem_src,
    input  logic [DW-1:0]     rdata,
    input  logic              rdata_ack,
    output logic [DW-1:0]     slave_rdata,
    output logic              slave_rdata_ack,
    output logic              timeout_err
);

    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  WAIT      = 1'b1;
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
    localparam logic [NM-1:0] ONE     = {{(NM-1){1'b0}}, 1'b1};

    logic [0:0]  state;
    logic [15:0] wdog;
    logic [1:0]  last;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        win_found;

    // Search starts just after the last winner; k=4 wraps back to last itself.
    always_comb begin
        win       = last;
        win_found = 1'b0;
        idx       = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!win_found && REQ[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            GNT             <= '0;
            mem_valid       <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wr          <= 1'b0;
            mem_src         <= 2'd0;
            slave_rdata     <= '0;
            slave_rdata_ack <= 1'b0;
            timeout_err     <= 1'b0;
            wdog            <= 16'd0;
            last            <= 2'd3;
        end else begin
            mem_valid       <= 1'b0;
            slave_rdata_ack <= 1'b0;
            timeout_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        GNT       <= ONE << win;
                        mem_src   <= win;
                        mem_addr  <= m_addr[win*AW +: AW];
                        mem_wdata <= m_wdata[win*DW +: DW];
                        mem_wr    <= m_wr[win];
                        mem_valid <= 1'b1;
                        wdog      <= 16'd0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    wdog <= wdog + 16'd1;
                    // An ack on the watchdog's final cycle still completes normally.
                    if (rdata_ack) begin
                        slave_rdata     <= rdata;
                        slave_rdata_ack <= 1'b1;
                        GNT             <= '0;
                        last            <= mem_src;
                        state           <= IDLE;
                    end else if (wdog == WDOG_LAST) begin
                        timeout_err <= 1'b1;
                        GNT         <= '0;
                        last        <= mem_src;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mem_sched.sv
// tb/tb_rr_mem_sched.sv - directed scoreboard bench for rr_mem_sched
module tb_rr_mem_sched;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   REQ = 4'd0;
    logic [127:0] m_addr;
    logic [127:0] m_wdata;
    logic [3:0]   m_wr = 4'b0101;
    logic [3:0]   GNT;
    logic         mem_valid;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_wr;
    logic [1:0]   mem_src;
    logic [31:0]  rdata = 32'd0;
    logic         rdata_ack = 1'b0;
    logic [31:0]  slave_rdata;
    logic         slave_rdata_ack;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    int          exp_gnt_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] held_rdata = 32'd0;

    rr_mem_sched #(.NM(4), .AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .REQ(REQ), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wr(m_wr), .GNT(GNT), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_src(mem_src), .rdata(rdata),
        .rdata_ack(rdata_ack), .slave_rdata(slave_rdata),
        .slave_rdata_ack(slave_rdata_ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 | (32'(i) << 8);
    endfunction

    function automatic logic [31:0] wdata_of(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ack_at: edge (counted from the mem_valid edge) at which ack is sampled; 0 = never ack.
    task automatic txn(input logic [3:0] req, input int exp_w, input int ack_at,
                       input logic [31:0] data, input bit drop);
        int n;
        int w;
        REQ = req;
        exp_gnt_q.push_back(exp_w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_valid && n < 20);
        chk("mem_valid_seen", 64'(mem_valid), 64'd1);
        chk("grant_latency", 64'(n), 64'd1);
        w = exp_gnt_q.pop_front();
        chk("gnt", 64'(GNT), 64'(4'd1 << w));
        chk("mem_src", 64'(mem_src), 64'(w));
        chk("mem_addr", 64'(mem_addr), 64'(addr_of(w)));
        chk("mem_wdata", 64'(mem_wdata), 64'(wdata_of(w)));
        chk("mem_wr", 64'(mem_wr), 64'(m_wr[w]));
        if (drop) REQ = 4'd0;
        if (ack_at > 0) begin
            for (int k = 1; k < ack_at; k++) begin
                @(negedge clk);
                if (k == 1) chk("mem_valid_pulse", 64'(mem_valid), 64'd0);
                chk("gnt_held", 64'(GNT), 64'(4'd1 << w));
            end
            rdata = data;
            rdata_ack = 1'b1;
            exp_data_q.push_back(data);
            @(negedge clk);
            rdata_ack = 1'b0;
            chk("slave_ack", 64'(slave_rdata_ack), 64'd1);
            chk("slave_rdata", 64'(slave_rdata), 64'(exp_data_q.pop_front()));
            chk("no_timeout", 64'(timeout_err), 64'd0);
            chk("gnt_bubble", 64'(GNT), 64'd0);
            held_rdata = data;
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!timeout_err && !slave_rdata_ack && n < 100);
            chk("timeout_cycles", 64'(n), 64'(TO));
            chk("timeout_err", 64'(timeout_err), 64'd1);
            chk("timeout_no_ack", 64'(slave_rdata_ack), 64'd0);
            chk("timeout_gnt", 64'(GNT), 64'd0);
            chk("timeout_rdata", 64'(slave_rdata), 64'(held_rdata));
        end
        REQ = 4'd0;
        @(negedge clk);
        chk("pulse_one_cycle", 64'({slave_rdata_ack, timeout_err}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_addr[i*32 +: 32]  = addr_of(i);
            m_wdata[i*32 +: 32] = wdata_of(i);
        end
        repeat (2) @(negedge clk);
        chk("rst_gnt", 64'(GNT), 64'd0);
        chk("rst_mem", 64'({mem_valid, mem_wr, mem_src, mem_addr}), 64'd0);
        chk("rst_slave", 64'({slave_rdata_ack, timeout_err, slave_rdata}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        txn(4'b0001, 0, 3, 32'hCAFE_0001, 1'b0);

        txn(4'b1111, 1, 2, 32'h0000_1111, 1'b0);
        txn(4'b1111, 2, 2, 32'h0000_2222, 1'b0);
        txn(4'b1111, 3, 2, 32'h0000_3333, 1'b0);
        txn(4'b1111, 0, 2, 32'h0000_0000, 1'b0);
        txn(4'b1111, 1, 2, 32'h0000_1112, 1'b0);

        txn(4'b1001, 3, 1, 32'h3333_0003, 1'b0);
        txn(4'b1001, 0, 1, 32'h0000_0004, 1'b0);

        txn(4'b0100, 2, 0, 32'h0, 1'b0);
        txn(4'b1000, 3, 2, 32'h8888_0003, 1'b0);

        txn(4'b0001, 0, TO, 32'h5A5A_0000, 1'b1);

        rdata = 32'hBAD0_BAD0;
        rdata_ack = 1'b1;
        @(negedge clk);
        rdata_ack = 1'b0;
        chk("stray_ack", 64'(slave_rdata_ack), 64'd0);
        chk("stray_rdata", 64'(slave_rdata), 64'(held_rdata));
        chk("stray_gnt", 64'(GNT), 64'd0);

        REQ = 4'b0100;
        @(negedge clk);
        chk("pre_reset_gnt", 64'(GNT), 64'b0100);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async_gnt", 64'(GNT), 64'd0);
        chk("async_mem", 64'({mem_valid, mem_wr, mem_src, mem_addr, mem_wdata}), 64'd0);
        chk("async_slave", 64'({slave_rdata_ack, timeout_err, slave_rdata}), 64'd0);
        REQ = 4'b0000;
        @(negedge clk);
        held_rdata = 32'd0;
        reset = 1'b1;
        txn(4'b1111, 0, 2, 32'h600D_0006, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
